branch_predictor: RTL

- Parametrised dynamic branch predictor for the 5-stage RISC-V pipeline.
- IF stage looks up the current PC combinationally and gets a taken/not-taken prediction plus a target. EX stage feeds back resolved branches to train the tables.
- Structure: direct-mapped BTB with per-entry 2-bit saturating counters. Replaces the static "always not-taken, flush on taken" policy and adds saturating branch/mispredict statistics counters.

---
 rtl/branch_predictor.sv | 94 +++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with per-entry 2-bit
// saturating counters, trained from EX, looked up combinationally from IF.
// Also keeps saturating counts of resolved branches and mispredictions.
module branch_predictor #(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  lk_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  input  logic             upd_valid,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [PC_W-1:0]  upd_target,
  input  logic             upd_mispred,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - 2 - IDX_W;

  logic             valid_q  [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [PC_W-1:0]  target_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;

  // Instructions are word aligned, so the two byte-offset bits carry no information.
  logic unused_pc_bits;
  assign unused_pc_bits = &{1'b0, lk_pc[1:0], upd_pc[1:0]};

  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign lk_tag  = lk_pc[PC_W-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[PC_W-1:IDX_W+2];

  // Zero-latency lookup against the current (pre-update) table contents.
  always_comb begin
    pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken  = pred_hit && ctr_q[lk_idx][1];
    pred_target = pred_hit ? target_q[lk_idx] : '0;
  end

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Table training: adjust counters on a tag hit, allocate only on a taken miss
  // so a not-taken alias never evicts a live entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        ctr_q[i]    <= 2'b01;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          target_q[upd_idx] <= upd_target;
          if (ctr_q[upd_idx] != 2'b11) ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
        end else if (ctr_q[upd_idx] != 2'b00) begin
          ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        ctr_q[upd_idx]    <= 2'b10;
      end
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else if (upd_valid) begin
      if (stat_branches != '1) stat_branches <= stat_branches + 1'b1;
      if (upd_mispred && (stat_mispred != '1)) stat_mispred <= stat_mispred + 1'b1;
    end
  end

endmodule
